// File: rtl/mbox_req_arb_pkg.sv
// mbox_arb_pkg: shared request/state types and one-hot mapping for the MBOX request arbiter
package mbox_arb_pkg;
  typedef enum logic [2:0] {NONE, MB, CCA, CHAN, EBOX} tArbReq;
  typedef enum logic [1:0] {IDLE, GRANT, BUSY} tArbState;
  // Bit order {mb, cca, chan, ebox} is used for every grant/cyc/eligible vector
  function automatic logic [3:0] req_onehot(tArbReq r);
    return r == MB ? 4'b1000 : r == CCA ? 4'b0100 : r == CHAN ? 4'b0010 : r == EBOX ? 4'b0001 : 4'b0000;
  endfunction
endpackage

// File: rtl/mbox_req_arb_if.sv
// mbox_req_arb_if: request/completion inputs and grant/cycle outputs between requesters, CSH and the arbiter
interface mbox_req_arb_if;
  logic mb_req, cca_req, chan_req, ebox_req, page_fail_hold, cyc_done, cyc_abort;
  logic mb_req_grant, cca_req_grant, chan_req_grant, ebox_req_grant;
  logic mb_cyc, cca_cyc, chan_cyc, ebox_cyc;
  logic ebox_retry_req, arb_idle, ebox_promoted;
  modport master (
    output mb_req, cca_req, chan_req, ebox_req, page_fail_hold, cyc_done, cyc_abort,
    input  mb_req_grant, cca_req_grant, chan_req_grant, ebox_req_grant,
    input  mb_cyc, cca_cyc, chan_cyc, ebox_cyc, ebox_retry_req, arb_idle, ebox_promoted
  );
  modport slave (
    input  mb_req, cca_req, chan_req, ebox_req, page_fail_hold, cyc_done, cyc_abort,
    output mb_req_grant, cca_req_grant, chan_req_grant, ebox_req_grant,
    output mb_cyc, cca_cyc, chan_cyc, ebox_cyc, ebox_retry_req, arb_idle, ebox_promoted
  );
endinterface

// File: rtl/mbox_req_arb_prio.sv
// mbox_arb_prio: fixed-priority picker; promotion lifts EBOX above CCA/CHAN but never above MB
module mbox_arb_prio
  import mbox_arb_pkg::*;
(
  input  logic [3:0] i_elig,
  input  logic       i_promoted,
  output tArbReq     o_win
);
  // Winner selection, highest priority first
  always_comb
    o_win = i_elig[3] ? MB :
            (i_promoted && i_elig[0]) ? EBOX :
            i_elig[2] ? CCA :
            i_elig[1] ? CHAN :
            i_elig[0] ? EBOX : NONE;
endmodule

// File: rtl/mbox_req_arb.sv
// mbox_req_arb: selects one memory-cycle requester, pulses its grant and holds its cycle level until CSH ends it
module mbox_req_arb
  import mbox_arb_pkg::*;
#(
  parameter  int STARVE_MAX = 4,
  localparam int CW = $clog2(STARVE_MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  mbox_req_arb_if.slave bus
);
  tArbState      r_state, w_state_nxt;
  tArbReq        r_owner, w_owner_nxt, w_win;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_retry, w_retry_nxt;
  logic [3:0]    w_elig, w_grant, w_cyc;
  logic          w_end, w_arb, w_promoted;

  assign w_elig     = {bus.mb_req, bus.cca_req, bus.chan_req, bus.ebox_req & ~bus.page_fail_hold};
  assign w_promoted = r_cnt == CW'(STARVE_MAX);

  mbox_arb_prio u_prio (.i_elig(w_elig), .i_promoted(w_promoted), .o_win(w_win));

  // Next state: arbitrate while idle or at the completing edge, so back-to-back cycles have no dead cycle
  always_comb begin
    w_end       = r_state != IDLE && (bus.cyc_done || bus.cyc_abort);
    w_arb       = r_state == IDLE || w_end;
    w_state_nxt = w_arb ? (w_win != NONE ? GRANT : IDLE) : BUSY;
    w_owner_nxt = w_arb ? w_win : r_owner;
    w_retry_nxt = w_end && bus.cyc_abort && r_owner == EBOX;
    w_cnt_nxt   = !w_arb ? r_cnt :
                  (!w_elig[0] || w_win == EBOX) ? '0 :
                  (w_win != NONE && !w_promoted) ? r_cnt + 1'b1 : r_cnt;
  end

  // State, owner, starvation count and retry pulse registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= NONE;
      r_cnt   <= '0;
      r_retry <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_retry <= w_retry_nxt;
    end

  assign w_grant = r_state == GRANT ? req_onehot(r_owner) : 4'b0000;
  assign w_cyc   = r_state != IDLE ? req_onehot(r_owner) : 4'b0000;
  assign {bus.mb_req_grant, bus.cca_req_grant, bus.chan_req_grant, bus.ebox_req_grant} = w_grant;
  assign {bus.mb_cyc, bus.cca_cyc, bus.chan_cyc, bus.ebox_cyc} = w_cyc;
  assign bus.ebox_retry_req = r_retry;
  assign bus.arb_idle       = r_state == IDLE;
  assign bus.ebox_promoted  = w_promoted;
endmodule

// File: tb/tb_mbox_req_arb.sv
// tb_mbox_req_arb: directed vector table plus hand sequences for page-fail hold and async reset
module tb_mbox_req_arb;
  typedef struct {
    logic [6:0]  in;
    logic [10:0] exp;
  } vec_t;

  logic clk, rst_n;
  int   errors = 0;
  int   checks = 0;
  vec_t vs[$];

  mbox_req_arb_if bus();
  mbox_req_arb #(.STARVE_MAX(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] outs();
    return {bus.mb_req_grant, bus.cca_req_grant, bus.chan_req_grant, bus.ebox_req_grant,
            bus.mb_cyc, bus.cca_cyc, bus.chan_cyc, bus.ebox_cyc,
            bus.ebox_retry_req, bus.arb_idle, bus.ebox_promoted};
  endfunction

  task automatic apply(input logic [6:0] in);
    {bus.mb_req, bus.cca_req, bus.chan_req, bus.ebox_req, bus.page_fail_hold, bus.cyc_done, bus.cyc_abort} = in;
  endtask

  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] got;
    got = outs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b (grant4 cyc4 retry idle promoted)", name, got, exp);
    end
  endtask

  initial begin
    // inputs: mb cca chan ebox pfh done abort; expected: grant[mb..ebox] cyc[mb..ebox] retry idle promoted
    vs.push_back('{7'b0001000, 11'b0001_0001_000});
    vs.push_back('{7'b0000000, 11'b0000_0001_000});
    vs.push_back('{7'b0000000, 11'b0000_0001_000});
    vs.push_back('{7'b0000010, 11'b0000_0000_010});
    vs.push_back('{7'b1111000, 11'b1000_1000_000});
    vs.push_back('{7'b0111010, 11'b0100_0100_000});
    vs.push_back('{7'b0011010, 11'b0010_0010_000});
    vs.push_back('{7'b0001010, 11'b0001_0001_000});
    vs.push_back('{7'b0000010, 11'b0000_0000_010});
    vs.push_back('{7'b0111000, 11'b0100_0100_000});
    vs.push_back('{7'b0111010, 11'b0100_0100_000});
    vs.push_back('{7'b0111010, 11'b0100_0100_000});
    vs.push_back('{7'b0111010, 11'b0100_0100_001});
    vs.push_back('{7'b1111010, 11'b1000_1000_001});
    vs.push_back('{7'b0111010, 11'b0001_0001_000});
    vs.push_back('{7'b0110010, 11'b0100_0100_000});
    vs.push_back('{7'b0000010, 11'b0000_0000_010});
    vs.push_back('{7'b0001000, 11'b0001_0001_000});
    vs.push_back('{7'b0000000, 11'b0000_0001_000});
    vs.push_back('{7'b0000011, 11'b0000_0000_110});
    vs.push_back('{7'b0000000, 11'b0000_0000_010});
    vs.push_back('{7'b0010000, 11'b0010_0010_000});
    vs.push_back('{7'b0000011, 11'b0000_0000_010});
    vs.push_back('{7'b0000011, 11'b0000_0000_010});
    vs.push_back('{7'b0001000, 11'b0001_0001_000});
    vs.push_back('{7'b0010001, 11'b0010_0010_100});
    vs.push_back('{7'b0000010, 11'b0000_0000_010});

    rst_n = 1'b0;
    apply(7'b0);
    repeat (2) @(negedge clk);
    check("reset", 11'b0000_0000_010);
    rst_n = 1'b1;

    for (int i = 0; i < vs.size(); i++) begin
      apply(vs[i].in);
      @(negedge clk);
      check($sformatf("vec%0d", i), vs[i].exp);
    end

    for (int i = 0; i < 10; i++) begin
      apply(7'b0001100);
      @(negedge clk);
      check($sformatf("pfh_hold%0d", i), 11'b0000_0000_010);
    end
    apply(7'b0001000);
    @(negedge clk);
    check("pfh_release", 11'b0001_0001_000);
    apply(7'b0000010);
    @(negedge clk);
    check("pfh_done", 11'b0000_0000_010);

    apply(7'b0010000);
    @(negedge clk);
    check("rst_chan_grant", 11'b0010_0010_000);
    @(negedge clk);
    check("rst_chan_busy", 11'b0000_0010_000);
    #2 rst_n = 1'b0;
    #1 check("rst_async_drop", 11'b0000_0000_010);
    @(negedge clk);
    check("rst_held", 11'b0000_0000_010);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_fresh_grant", 11'b0010_0010_000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mbox_req_arb.md
Name: mbox_req_arb

Overview:
- Request arbiter and cycle sequencer at the front of the MBOX cache controller (CSH).
- Accepts four memory-cycle requests: MB writeback, CCA cache sweep, channel, EBOX.
- Selects one, issues a one-cycle grant pulse, then holds a cycle-type level until CSH reports completion or abort.
- Its outputs drive the CSH grant/cycle signals (MB_REQ_GRANT, CCA_REQ_GRANT, CHAN_REQ_GRANT, EBOX_REQ_GRANT, MB_CYC, CCA_CYC, CHAN_CYC, EBOX_RETRY_REQ).

Parameters:
- STARVE_MAX, 4: consecutive EBOX losses before EBOX is promoted above CCA and channel.
- CW, $clog2(STARVE_MAX+1): starvation counter width (derived; not overridden).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mb_req  in  1  MB writeback request (level)
- cca_req  in  1  cache-sweep request (level)
- chan_req  in  1  channel request (level)
- ebox_req  in  1  EBOX request (level)
- page_fail_hold  in  1  EBOX requests are ineligible while high
- cyc_done  in  1  CSH: current cycle complete (1-cycle pulse)
- cyc_abort  in  1  CSH: current cycle terminated by error (1-cycle pulse)
- mb_req_grant, cca_req_grant, chan_req_grant, ebox_req_grant  out  1 each  grant pulses, one-hot
- mb_cyc, cca_cyc, chan_cyc, ebox_cyc  out  1 each  cycle-in-progress levels, one-hot
- ebox_retry_req  out  1  pulse: aborted EBOX cycle must be reissued
- arb_idle  out  1  no cycle in progress
- ebox_promoted  out  1  starvation promotion active

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values:
  - all grants, all cyc levels, ebox_retry_req and ebox_promoted = 0
  - arb_idle = 1; state = IDLE; starvation counter = 0
  - Reset mid-cycle drops every output immediately. No retry is generated.
- Priority, from highest:
  - Normal order: MB, CCA, CHAN, EBOX.
  - When ebox_promoted=1: MB, EBOX, CCA, CHAN.
  - MB is never preempted by promotion.
  - An EBOX request is eligible only when ebox_req=1 and page_fail_hold=0.
- States:
  - IDLE: if any request is eligible at edge N, go to GRANT. From edge N the winner's grant pulse and cyc level are both high. arb_idle=0.
  - GRANT: lasts exactly one cycle, with the grant pulse high. Go to BUSY, or handle done/abort this cycle (1-cycle operations are legal).
  - BUSY: cyc level held. Request inputs are ignored; there is no preemption.
- Completion:
  - cyc_done or cyc_abort sampled high in GRANT or BUSY ends the cycle.
  - The cyc level drops at the next edge.
  - If another request is eligible at that same edge, go directly to GRANT with the new winner: back-to-back, zero dead cycles.
  - Otherwise go to IDLE.
- Abort:
  - cyc_abort on an EBOX cycle gives an ebox_retry_req pulse at the edge where ebox_cyc drops.
  - cyc_abort on any other cycle type gives no retry.
  - cyc_done and cyc_abort together: abort wins.
  - done/abort in IDLE is ignored.
- Starvation counter:
  - At each grant to a non-EBOX requester while EBOX is eligible, increment, saturating at STARVE_MAX.
  - Clear on an EBOX grant, or when EBOX is ineligible at an arbitration point.
  - ebox_promoted = (counter == STARVE_MAX), registered with the counter.
- Invariants:
  - At most one grant and at most one cyc level high at any time.
  - A grant is always accompanied by its matching cyc level.
  - Requests dropping during BUSY do not affect the cycle in progress.

Decomposition:
- Package mbox_arb_pkg:
  - enum tArbReq {NONE, MB, CCA, CHAN, EBOX}
  - enum tArbState {IDLE, GRANT, BUSY}
  - function mapping tArbReq to the one-hot grant/cyc vectors
- Sub-module mbox_arb_prio: combinational priority picker. Inputs are the eligible request vector and the promotion flag; output is the winning tArbReq. It is unit-testable in isolation.

Test Plan:
- Reset → idle, then ebox_req=1 → ebox_req_grant one pulse and ebox_cyc high from the next edge; cyc_done 3 cycles later → ebox_cyc drops and arb_idle=1.
- mb_req, cca_req, chan_req, ebox_req all raised in one cycle, each completing with a 1-cycle cyc_done → grants in order MB, CCA, CHAN, EBOX; one-hot always holds.
- chan_req and ebox_req held, STARVE_MAX=4, cca_req pulsed before each arbitration → after 4 EBOX losses ebox_promoted=1 and EBOX beats CCA and CHAN; counter clears after the EBOX grant.
- EBOX cycle, then cyc_abort and cyc_done together → ebox_cyc drops and ebox_retry_req is one pulse; the same abort on a CHAN cycle → no retry pulse.
- ebox_req=1 with page_fail_hold=1 → no grant for 10 cycles; page_fail_hold drops → ebox_req_grant on the next edge.
- rst_n asserted while in BUSY during chan_cyc → all outputs 0 immediately; after release with chan_req still high → a fresh chan grant one cycle later.
